// File: rtl/tri_line_rx_if.sv
// ---------------------------------------------------------------------------
// tri_line_rx_if
// Bundles the wire input and the parallel result of the tristate line
// receiver.
//   master : the receiver. It takes line_in and drives the result signals.
//   slave  : the consumer or test side. It drives line_in and takes the result.
// Signals
//   line_in     raw wire level, asynchronous to clk
//   rx_data     last good decoded word
//   rx_valid    one-cycle pulse when rx_data updates
//   frame_err   one-cycle pulse when the stop bit was sampled low
//   parity_err  one-cycle pulse on a parity mismatch
//   busy        high while a frame is being received
// ---------------------------------------------------------------------------
interface tri_line_rx_if #(
    parameter int DATA_W = 8
);
    logic              line_in;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              parity_err;
    logic              busy;

    modport master (
        input  line_in,
        output rx_data, rx_valid, frame_err, parity_err, busy
    );

    modport slave (
        output line_in,
        input  rx_data, rx_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/tri_line_rx.sv
// ---------------------------------------------------------------------------
// tri_line_rx
// Receiver for a shared single-wire tristate line. The line idles high
// (released, pulled up). Remote drivers pull it low to send an inverted bit.
// The line is synchronised and the start edge is detected. Each bit is
// sampled once at its middle and re-inverted. DATA_W bits are shifted into
// a word and presented with a one-cycle valid strobe.
// Wire frame: start(0), DATA_W bits (~d, LSB first), [~parity], stop(1).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per wire bit; must be even and at least 4
//   DATA_W        data bits per frame, 1..16
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   bus.line_in   raw wire level
//   bus.rx_data   last good word
//   bus.rx_valid  one-cycle pulse when rx_data updates
//   bus.frame_err one-cycle pulse when the stop bit was low
//   bus.parity_err one-cycle pulse on a parity mismatch (tied 0 without parity)
//   bus.busy      high from start detect until the return to idle
// Configuration
//   TRI_RX_PARITY_EN  adds an even-parity bit after the data bits
// ---------------------------------------------------------------------------
module tri_line_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    tri_line_rx_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t            state;
    logic              sync_p0;
    logic              line_s;
    logic [CNT_W-1:0]  clk_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              frame_err_r;
    logic              busy_r;
`ifdef TRI_RX_PARITY_EN
    logic              par_bit;
    logic              par_err_r;
`endif

    // Shift right so that the first bit received (the wire LSB) ends up in bit 0.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                   input logic b);
        logic [DATA_W-1:0] r;
        r = s >> 1;
        r[DATA_W-1] = b;
        return r;
    endfunction

    wire mid_bit = (clk_cnt == FULL_LAST);

    // Control path: synchroniser, FSM, counters and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // The synchroniser is preset high so that reset reads as an idle line.
            state       <= IDLE;
            sync_p0     <= 1'b1;
            line_s      <= 1'b1;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef TRI_RX_PARITY_EN
            par_err_r   <= 1'b0;
`endif
        end else begin
            sync_p0     <= bus.line_in;
            line_s      <= sync_p0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
`ifdef TRI_RX_PARITY_EN
            par_err_r   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!line_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    // Recheck the line half a bit in. A glitch that has gone high
                    // again by then is not treated as a frame.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (line_s) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BITS_LAST) begin
                            bit_cnt <= '0;
`ifdef TRI_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef TRI_RX_PARITY_EN
                PARITY: begin
                    if (mid_bit) begin
                        clk_cnt <= '0;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // The frame ends at the stop-bit middle. The second half of the
                    // stop bit is spent in IDLE, ready for a back-to-back start.
                    if (mid_bit) begin
                        clk_cnt <= '0;
                        if (line_s) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
`ifdef TRI_RX_PARITY_EN
                            if (par_bit == ^shift) begin
                                rx_data_r  <= shift;
                                rx_valid_r <= 1'b1;
                            end else begin
                                par_err_r  <= 1'b1;
                            end
`else
                            rx_data_r  <= shift;
                            rx_valid_r <= 1'b1;
`endif
                        end else begin
                            frame_err_r <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A line stuck low must not be decoded as a train of start bits.
                    if (line_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Data path: the shift register and the parity sample. These are not reset.
    always_ff @(posedge clk) begin
        if (state == DATA && mid_bit)
            shift <= shift_in(shift, ~line_s);
`ifdef TRI_RX_PARITY_EN
        if (state == PARITY && mid_bit)
            par_bit <= ~line_s;
`endif
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
`ifdef TRI_RX_PARITY_EN
    assign bus.parity_err = par_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
